i2c_burst_controller: RTL and testbench

Parametrised I2C master that runs multi-byte write or read bursts to a 7-bit slave, succeeding the single-byte `i2c_controller`. Provides a programmable SCL divider, per-byte valid/ready streaming for write and read data, ACK checking with a sticky NACK flag, and optional slave clock stretching. Sits between on-chip control logic and the open-drain `i2c_sda`/`i2c_scl` pads, pairing with `i2c_slave_controller` on the bus.

---
 rtl/i2c_burst_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_burst_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_controller.sv
// i2c_burst_controller
//   I2C master running multi-byte write or read bursts to a 7-bit slave address.
//   Each bit frame is four quarter-phases of CLK_DIV clocks: SCL low for q0/q1 and
//   released for q2/q3. SDA changes only at the start of q0 and is sampled on entry to q3.
//
// Parameters
//   CLK_DIV  clk cycles per SCL quarter-phase (>= 2)
//   LEN_W    width of the byte count; maximum burst is 2^LEN_W - 1 bytes
//
// Ports
//   clk, rst               system clock; asynchronous active-low reset
//   addr, rw, len, enable  burst request, sampled when enable is seen while ready
//   wr_data/valid/ready    write byte stream (one byte per handshake)
//   rd_data, rd_valid      read byte stream, one-cycle pulse per byte
//   ready, done, nack      idle flag, STOP-complete pulse, sticky ACK-slot-read-1 flag
//   i2c_sda, i2c_scl       open-drain bus lines (driven 0 or Z only)
//
// Build option
//   I2C_STRETCH_EN  when defined, a released SCL that reads 0 during q2/q3 holds the
//                   quarter timer (slave clock stretching). Otherwise SCL is never read.

module i2c_burst_controller #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned LEN_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       addr,
   input  logic             rw,
   input  logic [LEN_W-1:0] len,
   input  logic             enable,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             ready,
   output logic             done,
   output logic             nack,
   inout  wire              i2c_sda,
   inout  wire              i2c_scl
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      StIdle, StStart, StAddr, StAddrAck, StWload,
      StWdata, StWack, StRdata, StRack, StStop
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [LEN_W-1:0] bcnt_q, bcnt_d;
   logic             rw_q, rw_d;
   logic             ack_q, ack_d;
   logic             nack_q, nack_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             done_q, done_d;

   logic sda_low, scl_low, sda_in;
   logic frame, stall, q_end, frame_end, sample;

   assign sda_in = i2c_sda;
   assign frame  = state_q inside {StAddr, StAddrAck, StWdata, StWack, StRdata, StRack};

`ifdef I2C_STRETCH_EN
   // We only release SCL in q2/q3, so a low reading there is the slave holding it.
   assign stall = frame && qtr_q[1] && !i2c_scl;
`else
   logic unused_scl;
   assign unused_scl = i2c_scl;
   assign stall      = 1'b0;
`endif

   assign q_end     = (cnt_q == CntMax) && !stall;
   assign frame_end = q_end && (qtr_q == 2'd3);
   assign sample    = q_end && (qtr_q == 2'd2);  // edge entering q3

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      qtr_d      = qtr_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      bcnt_d     = bcnt_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      nack_d     = nack_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      sda_low    = 1'b0;
      scl_low    = 1'b0;
      wr_ready   = 1'b0;

      // Quarter-phase timebase; qtr wraps 3 -> 0 at each frame end.
      if (!stall) begin
         if (q_end) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            qtr_d = '0;
            if (enable) begin
               shreg_d = {addr, rw};
               rw_d    = rw;
               bcnt_d  = len;
               nack_d  = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            sda_low = qtr_q[0];
            if (q_end && qtr_q == 2'd1) begin
               qtr_d   = '0;
               bit_d   = '0;
               state_d = StAddr;
            end
         end
         StAddr, StWdata: begin
            scl_low = !qtr_q[1];
            sda_low = !shreg_q[7];
            if (frame_end) begin
               shreg_d = {shreg_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = (state_q == StAddr) ? StAddrAck : StWack;
               end
            end
         end
         StAddrAck: begin
            scl_low = !qtr_q[1];
            if (sample) ack_d = sda_in;
            if (frame_end) begin
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else if (bcnt_q == '0) begin
                  state_d = StStop;
               end else begin
                  state_d = rw_q ? StRdata : StWload;
               end
            end
         end
         StWload: begin
            scl_low  = 1'b1;
            wr_ready = 1'b1;
            cnt_d    = '0;
            qtr_d    = '0;
            if (wr_valid) begin
               shreg_d = wr_data;
               bit_d   = '0;
               state_d = StWdata;
            end
         end
         StWack: begin
            scl_low = !qtr_q[1];
            if (sample) ack_d = sda_in;
            if (frame_end) begin
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else begin
                  bcnt_d  = bcnt_q - LEN_W'(1);
                  state_d = (bcnt_q == LEN_W'(1)) ? StStop : StWload;
               end
            end
         end
         StRdata: begin
            scl_low = !qtr_q[1];
            if (sample) begin
               shreg_d = {shreg_q[6:0], sda_in};
               if (bit_q == 3'd7) begin
                  rd_data_d  = {shreg_q[6:0], sda_in};
                  rd_valid_d = 1'b1;
               end
            end
            if (frame_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = StRack;
            end
         end
         StRack: begin
            scl_low = !qtr_q[1];
            // ACK while more bytes are wanted; NACK tells the slave the burst is over.
            sda_low = (bcnt_q != LEN_W'(1));
            if (frame_end) begin
               bcnt_d  = bcnt_q - LEN_W'(1);
               state_d = (bcnt_q == LEN_W'(1)) ? StStop : StRdata;
            end
         end
         StStop: begin
            scl_low = (qtr_q == 2'd0);
            sda_low = (qtr_q != 2'd2);
            if (q_end && qtr_q == 2'd2) begin
               qtr_d   = '0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         qtr_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         bcnt_q     <= '0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         bcnt_q     <= bcnt_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         nack_q     <= nack_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign done     = done_q;
   assign nack     = nack_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   // Drive enables decode straight from reset flops, so reset releases the bus at once.
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;
   assign i2c_scl = scl_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_burst_controller.sv
// Bench for i2c_burst_controller: a bus-level slave responder at address 7'h56 plus a
// transaction-level reference (expected bus bytes, read stream, master ACKs, handshakes
// and burst duration) derived from the request alone.

module tb_i2c_burst_controller;

   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned LEN_W    = 4;
   localparam logic [6:0]  SLV_ADDR = 7'h56;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       addr;
   logic             rw;
   logic [LEN_W-1:0] len;
   logic             enable;
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             ready;
   logic             done;
   logic             nack;

   wire  sda_bus, scl_bus;
   logic s_drive = 1'b0;
   logic s_hold  = 1'b0;

   pullup pu_sda (sda_bus);
   pullup pu_scl (scl_bus);
   assign sda_bus = s_drive ? 1'b0 : 1'bz;
   assign scl_bus = s_hold ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_burst_controller #(
      .CLK_DIV (CLK_DIV),
      .LEN_W   (LEN_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .rw       (rw),
      .len      (len),
      .enable   (enable),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .ready    (ready),
      .done     (done),
      .nack     (nack),
      .i2c_sda  (sda_bus),
      .i2c_scl  (scl_bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Shared state between stimulus, slave and monitors.
   logic [7:0] slv_rd [16];
   logic [7:0] obs[$];
   logic       mack[$];
   logic [7:0] rd_got[$];
   logic [7:0] wr_q[$];
   logic [7:0] tx_bytes[$];
   int         starts, stops, hs_cnt, done_cnt, hold_cnt;
   bit         wr_hold   = 1'b0;
   bit         stretch_on = 1'b0;

   // Bus slave: polls the lines every falling clk edge.
   initial begin
      logic       p_sda, p_scl, sda, scl, rdp;
      logic       s_active, s_rd, s_match, s_mnack;
      logic [7:0] s_sh, s_cur;
      int         s_bit, s_idx;
      p_sda = 1'b1; p_scl = 1'b1; s_active = 1'b0; s_rd = 1'b0; s_match = 1'b0;
      s_mnack = 1'b0; s_sh = '0; s_cur = '0; s_bit = 0; s_idx = 0;
      starts = 0; stops = 0; hold_cnt = 0;
      forever begin
         @(negedge clk);
         sda = sda_bus;
         scl = scl_bus;
         if (!rst) begin
            s_active = 1'b0; s_drive = 1'b0; s_hold = 1'b0; hold_cnt = 0;
         end else begin
            if (hold_cnt > 0) begin
               hold_cnt--;
               if (hold_cnt == 0) s_hold = 1'b0;
            end
            rdp = s_rd && s_match && (s_idx > 0);
            if (p_scl && scl && p_sda && !sda) begin
               starts++;
               s_active = 1'b1; s_bit = -1; s_idx = 0; s_drive = 1'b0;
               s_rd = 1'b0; s_match = 1'b0; s_mnack = 1'b0;
            end else if (p_scl && scl && !p_sda && sda) begin
               stops++;
               s_active = 1'b0; s_drive = 1'b0;
            end else if (s_active && !p_scl && scl) begin
               if (s_bit >= 0 && s_bit < 8) begin
                  if (!rdp) s_sh = {s_sh[6:0], sda};
               end else if (s_bit == 8 && rdp) begin
                  mack.push_back(sda);
                  if (sda) s_mnack = 1'b1;
               end
            end else if (s_active && p_scl && !scl) begin
               s_bit++;
               if (s_bit == 8) begin
                  if (!rdp) begin
                     obs.push_back(s_sh);
                     if (s_idx == 0) begin
                        s_rd    = s_sh[0];
                        s_match = (s_sh[7:1] == SLV_ADDR);
                     end
                     s_drive = s_match;
                  end else begin
                     s_drive = 1'b0;
                  end
               end else if (s_bit == 9) begin
                  s_bit = 0;
                  s_idx++;
                  s_drive = 1'b0;
                  if (s_rd && s_match && !s_mnack && s_idx <= 16) begin
                     s_cur   = slv_rd[s_idx-1];
                     s_drive = !s_cur[7];
                  end
               end else if (rdp && s_bit > 0) begin
                  s_drive = !s_cur[7-s_bit];
               end
               if (stretch_on && s_idx == 0 && s_bit == 3) begin
                  s_hold   = 1'b1;
                  hold_cnt = 2*CLK_DIV + 20;
               end
            end
         end
         p_sda = sda;
         p_scl = scl;
      end
   end

   // Write-data feeder: offers the next byte while wr_ready is high.
   initial begin
      hs_cnt = 0;
      forever begin
         @(negedge clk);
         if (wr_valid) begin
            wr_valid = 1'b0;
            hs_cnt++;
            if (wr_q.size() > 0) void'(wr_q.pop_front());
         end else if (rst && wr_ready && !wr_hold && wr_q.size() > 0) begin
            wr_data  = wr_q[0];
            wr_valid = 1'b1;
         end
      end
   end

   // Read-stream and done monitor.
   initial begin
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (rd_valid) rd_got.push_back(rd_data);
         if (done) done_cnt++;
      end
   end

   task automatic run_txn(input logic [6:0] a, input logic r, input int n, input int extra,
                          input string name);
      logic [7:0] exp_obs[$];
      logic [7:0] exp_rd[$];
      logic       exp_mack[$];
      bit         match;
      int         exp_cyc, cyc;
      match = (a == SLV_ADDR);
      obs.delete(); mack.delete(); rd_got.delete(); wr_q.delete();
      hs_cnt = 0; done_cnt = 0; starts = 0; stops = 0;
      while (tx_bytes.size() < n) tx_bytes.push_back(8'($urandom));
      // Reference: what the bus and streams must show for this request.
      exp_obs.push_back({a, r});
      for (int i = 0; i < n; i++) begin
         if (r) begin
            slv_rd[i] = tx_bytes[i];
            if (match) begin
               exp_rd.push_back(tx_bytes[i]);
               exp_mack.push_back(i == n - 1);
            end
         end else begin
            wr_q.push_back(tx_bytes[i]);
            if (match) exp_obs.push_back(tx_bytes[i]);
         end
      end
      exp_cyc = 41*CLK_DIV + extra + (match ? n * (36*CLK_DIV + (r ? 0 : 1)) : 0);

      @(negedge clk);
      check({name, ".ready_idle"}, 32'(ready), 32'd1);
      addr = a; rw = r; len = LEN_W'(n); enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      check({name, ".ready_fall"}, 32'(ready), 32'd0);
      cyc = 1;
      while (!done && cyc < 41*CLK_DIV + 16*40*CLK_DIV) begin
         @(negedge clk);
         cyc++;
         // A request while busy must be ignored.
         if (cyc == 7) begin
            enable = 1'b1; addr = ~a; rw = ~r;
         end else if (cyc == 8) begin
            enable = 1'b0;
         end
      end
      check({name, ".cycles"}, 32'(cyc - 1), 32'(exp_cyc));
      check({name, ".ready_with_done"}, 32'(ready), 32'd1);
      repeat (2) @(negedge clk);
      check({name, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({name, ".nack"}, 32'(nack), 32'(!match));
      check({name, ".start_stop"}, 32'(starts * 16 + stops), 32'h11);
      check({name, ".hs"}, 32'(hs_cnt), 32'((match && !r) ? n : 0));
      check({name, ".obs_n"}, 32'(obs.size()), 32'(exp_obs.size()));
      for (int i = 0; i < exp_obs.size(); i++)
         check({name, ".obs"}, (i < obs.size()) ? 32'(obs[i]) : 32'hdead_beef,
               32'(exp_obs[i]));
      check({name, ".rd_n"}, 32'(rd_got.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size(); i++)
         check({name, ".rd"}, (i < rd_got.size()) ? 32'(rd_got[i]) : 32'hdead_beef,
               32'(exp_rd[i]));
      check({name, ".mack_n"}, 32'(mack.size()), 32'(exp_mack.size()));
      for (int i = 0; i < exp_mack.size(); i++)
         check({name, ".mack"}, (i < mack.size()) ? 32'(mack[i]) : 32'hdead_beef,
               32'(exp_mack[i]));
      tx_bytes.delete();
   endtask

   initial begin
      logic [6:0] ra;
      logic       rr;
      int         rn, hi, w;
      rst = 1'b0; enable = 1'b0; addr = '0; rw = 1'b0; len = '0;
      wr_data = '0; wr_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.ready", 32'(ready), 32'd1);
      check("rst.wr_ready", 32'(wr_ready), 32'd0);
      check("rst.rd_valid", 32'(rd_valid), 32'd0);
      check("rst.rd_data", 32'(rd_data), 32'h00);
      check("rst.done", 32'(done), 32'd0);
      check("rst.nack", 32'(nack), 32'd0);
      check("rst.sda", 32'(sda_bus), 32'd1);
      check("rst.scl", 32'(scl_bus), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      tx_bytes = '{8'hAA, 8'h55};
      run_txn(SLV_ADDR, 1'b0, 2, 0, "write");
      tx_bytes = '{8'h12, 8'h34, 8'h56};
      run_txn(SLV_ADDR, 1'b1, 3, 0, "read");
      run_txn(7'h11, 1'b0, 2, 0, "addr_nack");
      run_txn(SLV_ADDR, 1'b0, 0, 0, "probe");

`ifdef I2C_STRETCH_EN
      stretch_on = 1'b1;
      run_txn(SLV_ADDR, 1'b0, 0, 20, "stretch");
      stretch_on = 1'b0;
`endif

      // Stalled write stream followed by a mid-transfer reset.
      wr_hold = 1'b1;
      @(negedge clk);
      addr = SLV_ADDR; rw = 1'b0; len = LEN_W'(2); enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      w = 0;
      while (!wr_ready && w < 60*CLK_DIV) begin
         @(negedge clk);
         w++;
      end
      check("stall.wr_ready", 32'(wr_ready), 32'd1);
      hi = 0;
      repeat (50) begin
         @(negedge clk);
         if (scl_bus !== 1'b0) hi++;
      end
      check("stall.scl_low", 32'(hi), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("stall_rst.sda", 32'(sda_bus), 32'd1);
      check("stall_rst.scl", 32'(scl_bus), 32'd1);
      check("stall_rst.ready", 32'(ready), 32'd1);
      check("stall_rst.wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      wr_hold = 1'b0;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 10; t++) begin
         rr = 1'($urandom_range(0, 1));
         rn = int'($urandom_range(0, 4));
         if (rn == 0) rr = 1'b0;
         ra = ($urandom_range(0, 3) == 0) ? (SLV_ADDR ^ 7'($urandom_range(1, 127))) : SLV_ADDR;
         run_txn(ra, rr, rn, 0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
